// File: rtl/cmos_pattern_gen.sv
// CMOS image-sensor emulator: drives pclk / cmos_vsync / cmos_hsync / pix_cmos
// with a test pattern (spot, x-ramp, checkerboard or flat background).
// Optional macro PATGEN_NOISE_EN adds LFSR noise to background pixels.
module cmos_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_BLANK    = 144,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BACK     = 17,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned PCLK_DIV   = 2,
  parameter int unsigned X_W        = 10,
  parameter int unsigned Y_W        = 9,
  parameter int unsigned SPOT_HALF  = 4,
  parameter int unsigned BG_LEVEL   = 16,
  parameter int unsigned SPOT_LEVEL = 240
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           enable,
  input  logic [1:0]     pattern_sel,
  input  logic [X_W-1:0] spot_x,
  input  logic [Y_W-1:0] spot_y,
  output logic           pclk,
  output logic           cmos_vsync,
  output logic           cmos_hsync,
  output logic [7:0]     pix_cmos,
  output logic           frame_done,
  output logic [7:0]     frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned DW      = $clog2(PCLK_DIV);
  localparam int unsigned VM1     = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int unsigned VM2     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX   = (VM1 > VM2) ? VM1 : VM2;
  localparam int unsigned LW      = $clog2(V_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t         state;
  logic [DW-1:0]  div, div_next;
  logic [HW-1:0]  hcnt;
  logic [LW-1:0]  lcnt, phase_last;
  logic [1:0]     sel_q;
  logic [X_W-1:0] sx_q;
  logic [Y_W-1:0] sy_q;
  logic           tick, line_end, phase_end, active_px, in_spot;
  logic [15:0]    xw, yw, sxw, syw;
  logic [7:0]     bg, pix_next;
`ifdef PATGEN_NOISE_EN
  logic [15:0]    lfsr;
`endif

  // Timing decode and pixel value for the position about to be presented
  always_comb begin
    div_next   = (div == DW'(PCLK_DIV - 1)) ? '0 : div + 1'b1;
    tick       = (state != S_IDLE) && (div == DW'(PCLK_DIV - 1));
    case (state)
      S_VSYNC:  phase_last = LW'(V_SYNC - 1);
      S_VBACK:  phase_last = LW'(V_BACK - 1);
      S_ACTIVE: phase_last = LW'(V_ACTIVE - 1);
      S_VFRONT: phase_last = LW'(V_FRONT - 1);
      default:  phase_last = '0;
    endcase
    line_end   = (hcnt == HW'(H_TOTAL - 1));
    phase_end  = line_end && (lcnt == phase_last);
    active_px  = (state == S_ACTIVE) && (hcnt < HW'(H_ACTIVE));
    xw         = 16'(hcnt);
    yw         = 16'(lcnt);
    sxw        = 16'(sx_q);
    syw        = 16'(sy_q);
    // Distances compared as one-sided widened sums so the spot clips at edges
    in_spot    = (xw + 16'(SPOT_HALF) >= sxw) && (xw <= sxw + 16'(SPOT_HALF)) &&
                 (yw + 16'(SPOT_HALF) >= syw) && (yw <= syw + 16'(SPOT_HALF));
`ifdef PATGEN_NOISE_EN
    bg         = 8'(BG_LEVEL) + {5'b0, lfsr[2:0]};
`else
    bg         = 8'(BG_LEVEL);
`endif
    case (sel_q)
      2'b00:   pix_next = in_spot ? 8'(SPOT_LEVEL) : bg;
      2'b01:   pix_next = xw[7:0];
      2'b10:   pix_next = (xw[3] ^ yw[3]) ? 8'hFF : 8'h00;
      default: pix_next = bg;
    endcase
  end

  // Frame FSM, pclk divider, raster counters and registered sensor outputs
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= S_IDLE;
      div        <= '0;
      hcnt       <= '0;
      lcnt       <= '0;
      sel_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      pclk       <= 1'b0;
      cmos_vsync <= 1'b0;
      cmos_hsync <= 1'b0;
      pix_cmos   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef PATGEN_NOISE_EN
      lfsr       <= 16'hACE1;
`endif
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        div  <= '0;
        pclk <= 1'b0;
        if (enable) begin
          state <= S_VSYNC;
          hcnt  <= '0;
          lcnt  <= '0;
          sel_q <= pattern_sel;
          sx_q  <= spot_x;
          sy_q  <= spot_y;
        end
      end else begin
        div  <= div_next;
        pclk <= (div_next >= DW'(PCLK_DIV / 2));
        if (tick) begin
          cmos_vsync <= (state == S_VSYNC);
          cmos_hsync <= active_px;
          pix_cmos   <= active_px ? pix_next : '0;
`ifdef PATGEN_NOISE_EN
          lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`endif
          hcnt <= line_end ? '0 : hcnt + 1'b1;
          if (phase_end) begin
            lcnt <= '0;
            case (state)
              S_VSYNC:  state <= S_VBACK;
              S_VBACK:  state <= S_ACTIVE;
              S_ACTIVE: state <= S_VFRONT;
              S_VFRONT: begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
                if (enable) begin
                  state <= S_VSYNC;
                  sel_q <= pattern_sel;
                  sx_q  <= spot_x;
                  sy_q  <= spot_y;
                end else begin
                  state <= S_IDLE;
                end
              end
              default:  state <= S_IDLE;
            endcase
          end else if (line_end) begin
            lcnt <= lcnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// Scoreboard bench for cmos_pattern_gen using a reduced 8x6 raster.
module tb_cmos_pattern_gen;

  localparam int H_TOT  = 12;
  localparam int F_TICK = 108;

  logic       clk = 1'b0;
  logic       nRst, enable;
  logic [1:0] pattern_sel;
  logic [9:0] spot_x;
  logic [8:0] spot_y;
  logic       pclk, cmos_vsync, cmos_hsync, frame_done;
  logic [7:0] pix_cmos, frame_cnt;

  always #5 clk = ~clk;

  cmos_pattern_gen #(
    .H_ACTIVE(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(6), .V_FRONT(1),
    .PCLK_DIV(2), .X_W(10), .Y_W(9), .SPOT_HALF(1), .BG_LEVEL(16), .SPOT_LEVEL(240)
  ) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .pattern_sel(pattern_sel),
    .spot_x(spot_x), .spot_y(spot_y), .pclk(pclk), .cmos_vsync(cmos_vsync),
    .cmos_hsync(cmos_hsync), .pix_cmos(pix_cmos), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [18:0] word;  // {vsync, hsync, frame_done, frame_cnt, pix}
    bit          bg;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, fd_seen = 0;
  logic prev_pclk = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model(input int i, input int sel, input int sx, input int sy, input int cnt0);
    exp_t e;
    int line, x, y, pix, cnt;
    bit vs, hs, fd, act;
    line = i / H_TOT;
    x    = i % H_TOT;
    y    = line - 2;
    vs   = (line == 0);
    act  = (line >= 2) && (line < 8) && (x < 8);
    hs   = act;
    fd   = (i == F_TICK - 1);
    cnt  = fd ? cnt0 + 1 : cnt0;
    pix  = 0;
    e.bg = 0;
    if (act) begin
      case (sel)
        0: begin
          if (iabs(x - sx) <= 1 && iabs(y - sy) <= 1) pix = 240;
          else begin pix = 16; e.bg = 1; end
        end
        1: pix = x & 255;
        2: pix = (((x >> 3) ^ (y >> 3)) & 1) ? 255 : 0;
        default: begin pix = 16; e.bg = 1; end
      endcase
    end
    e.word = {vs, hs, fd, 8'(cnt), 8'(pix)};
    return e;
  endfunction

  task automatic push_frame(input int sel, input int sx, input int sy, input int cnt0);
    for (int i = 0; i < F_TICK; i++) sb.push_back(model(i, sel, sx, sy, cnt0));
  endtask

  task automatic wait_fd(input int target);
    for (int c = 0; c < 2000 && fd_seen < target; c++) @(negedge clk);
    check_eq("frame_done_seen", fd_seen, target);
  endtask

  task automatic check_idle(input string tag);
    int highs;
    highs = 0;
    repeat (60) @(negedge clk) if (pclk) highs++;
    check_eq(tag, highs, 0);
  endtask

  exp_t        mon_e;
  logic [18:0] mon_got;

  // Monitor: one pixel per falling pclk, compared against the scoreboard head
  always @(negedge clk) begin
    if (!nRst) begin
      prev_pclk = 1'b0;
    end else begin
      if (prev_pclk && !pclk) begin
        check_eq("tick_queued", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e   = sb.pop_front();
          mon_got = {cmos_vsync, cmos_hsync, frame_done, frame_cnt, pix_cmos};
`ifdef PATGEN_NOISE_EN
          if (mon_e.bg) begin
            check_eq("px_ctl", mon_got[18:8], mon_e.word[18:8]);
            check_eq("px_noise_bg", (pix_cmos >= 8'd16) && (pix_cmos <= 8'd23), 1);
          end else begin
            check_eq("px", mon_got, mon_e.word);
          end
`else
          check_eq("px", mon_got, mon_e.word);
`endif
        end
        if (frame_done) fd_seen++;
      end
      prev_pclk = pclk;
    end
  end

  initial begin
    int found;
    nRst = 1'b0; enable = 1'b0; pattern_sel = 2'b11; spot_x = '0; spot_y = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {pclk, cmos_vsync, cmos_hsync, frame_done, pix_cmos, frame_cnt}, 0);
    nRst = 1'b1;

    // enable low: nothing moves for 100 clocks
    found = 0;
    repeat (100) @(negedge clk) if (pclk || cmos_vsync) found++;
    check_eq("idle_static", found, 0);

    // frame 1 flat; frame-2 inputs changed mid-frame 1 must not leak into it
    push_frame(3, 0, 0, 0);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    pattern_sel = 2'b00; spot_x = 10'd3; spot_y = 9'd2;
    push_frame(0, 3, 2, 1);
    wait_fd(1);
    spot_x = 10'd0; spot_y = 9'd0;
    push_frame(0, 0, 0, 2);
    wait_fd(2);
    // mid-frame change then enable drop: frame 3 keeps (0,0) and completes
    spot_x = 10'd5; enable = 1'b0;
    wait_fd(3);
    check_idle("pclk_stopped");
    check_eq("cnt_after3", frame_cnt, 3);
    check_eq("sb_drained", sb.size(), 0);

    // reset during an active line
    pattern_sel = 2'b00; spot_x = 10'd3; spot_y = 9'd2;
    push_frame(0, 3, 2, 3);
    enable = 1'b1;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cmos_hsync) begin found = 1; break; end
    end
    check_eq("hsync_reached", found, 1);
    #2 nRst = 1'b0;
    #1 check_eq("async_rst_outs", {pclk, cmos_vsync, cmos_hsync, frame_done, pix_cmos, frame_cnt}, 0);
    sb.delete();
    fd_seen = 0;
    pattern_sel = 2'b01;
    push_frame(1, 3, 2, 0);
    @(negedge clk);
    nRst = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    wait_fd(1);
    check_idle("pclk_stopped_rst");
    check_eq("cnt_after_rst", frame_cnt, 1);
    check_eq("sb_drained_rst", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
